// File: rtl/pid_controller_mc_if.sv
// rtl/pid_controller_mc_if.sv - control, gain, process-value and result bundle for pid_controller_mc
interface pid_controller_mc_if #(
    parameter int NUM_CH        = 2,
    parameter int PID_INT_WIDTH = 16,
    parameter int PV_WIDTH      = 7,
    parameter int CONTROL_WIDTH = 18
);
    logic                              clk_en;
    logic                              en;
    logic                              start;
    logic [NUM_CH*PID_INT_WIDTH-1:0]   k_p;
    logic [NUM_CH*PID_INT_WIDTH-1:0]   k_i;
    logic [NUM_CH*PID_INT_WIDTH-1:0]   k_d;
    logic [NUM_CH*PV_WIDTH-1:0]        setpoint;
    logic [NUM_CH*PV_WIDTH-1:0]        feedback;
    logic                              busy;
    logic                              done;
    logic                              overrun;
    logic [NUM_CH-1:0]                 sat;
    logic [NUM_CH*(PV_WIDTH+1)-1:0]    error;
    logic [NUM_CH*CONTROL_WIDTH-1:0]   control_out;

    modport master (
        output clk_en, en, start, k_p, k_i, k_d, setpoint, feedback,
        input  busy, done, overrun, sat, error, control_out
    );

    modport slave (
        input  clk_en, en, start, k_p, k_i, k_d, setpoint, feedback,
        output busy, done, overrun, sat, error, control_out
    );
endinterface

// File: rtl/pid_controller_mc.sv
// rtl/pid_controller_mc.sv - time-multiplexed multi-channel PID with one shared multiplier
// Optional conditional-integration anti-windup: define PID_MC_ANTIWINDUP_EN.
module pid_controller_mc #(
    parameter int NUM_CH        = 2,
    parameter int PID_INT_WIDTH = 16,
    parameter int PV_WIDTH      = 7,
    parameter int CONTROL_WIDTH = 18,
    parameter int ACC_WIDTH     = 16,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    pid_controller_mc_if.slave   bus
);
    localparam int E_W    = PV_WIDTH + 1;
    localparam int D_W    = E_W + 1;
    localparam int G_W    = PID_INT_WIDTH + 1;
    localparam int B_W    = ACC_WIDTH + 1;
    localparam int PROD_W = G_W + B_W;
    localparam int SUM_W  = (PROD_W + 2 > CONTROL_WIDTH) ? PROD_W + 2 : CONTROL_WIDTH + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic signed [SUM_W-1:0] CTRL_MAX =
        {{(SUM_W-CONTROL_WIDTH+1){1'b0}}, {(CONTROL_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] CTRL_MIN = ~CTRL_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT, S_FIN, S_DONE
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CH_W-1:0]               r_ch;

    logic [PID_INT_WIDTH-1:0]      r_kp   [NUM_CH];
    logic [PID_INT_WIDTH-1:0]      r_ki   [NUM_CH];
    logic [PID_INT_WIDTH-1:0]      r_kd   [NUM_CH];
    logic [PV_WIDTH-1:0]           r_sp   [NUM_CH];
    logic [PV_WIDTH-1:0]           r_fb   [NUM_CH];
    logic signed [ACC_WIDTH-1:0]   r_acc  [NUM_CH];
    logic signed [E_W-1:0]         r_prev [NUM_CH];
    logic signed [E_W-1:0]         r_err  [NUM_CH];
    logic signed [CONTROL_WIDTH-1:0] r_ctrl [NUM_CH];
    logic [NUM_CH-1:0]             r_sat;
    logic                          r_overrun;

    logic signed [E_W-1:0]         r_e;
    logic signed [ACC_WIDTH-1:0]   r_acc_t;
    logic signed [SUM_W-1:0]       r_sum;

    logic signed [E_W-1:0]         w_e;
    logic signed [ACC_WIDTH:0]     w_acc_wide;
    logic signed [ACC_WIDTH-1:0]   w_acc_t;
    logic signed [D_W-1:0]         w_d;
    logic signed [G_W-1:0]         w_mul_a;
    logic signed [B_W-1:0]         w_mul_b;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [SUM_W-1:0]       w_s;
    logic                          w_clip_hi;
    logic                          w_clip_lo;
    logic signed [CONTROL_WIDTH-1:0] w_ctrl;
    logic                          w_hold;
    logic                          w_last;
    logic [NUM_CH*CONTROL_WIDTH-1:0] w_ctrl_bus;
    logic [NUM_CH*E_W-1:0]         w_err_bus;

    assign w_e        = $signed({1'b0, r_sp[r_ch]}) - $signed({1'b0, r_fb[r_ch]});
    assign w_acc_wide = (ACC_WIDTH+1)'(r_acc[r_ch]) + (ACC_WIDTH+1)'(r_e);
    assign w_d        = D_W'(r_e) - D_W'(r_prev[r_ch]);
    assign w_last     = (r_ch == CH_W'(NUM_CH - 1));

    // Integrator add saturates instead of wrapping when the top two bits disagree.
    always_comb begin
        w_acc_t = w_acc_wide[ACC_WIDTH-1:0];
        if (w_acc_wide[ACC_WIDTH] != w_acc_wide[ACC_WIDTH-1]) begin
            w_acc_t = w_acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_MP: begin
                w_mul_a = $signed({1'b0, r_kp[r_ch]});
                w_mul_b = B_W'(r_e);
            end
            S_MI: begin
                w_mul_a = $signed({1'b0, r_ki[r_ch]});
                w_mul_b = B_W'(w_acc_t);
            end
            S_MD: begin
                w_mul_a = $signed({1'b0, r_kd[r_ch]});
                w_mul_b = B_W'(w_d);
            end
            default: ;
        endcase
    end

    assign w_prod    = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
    assign w_s       = r_sum >>> OUT_SHIFT;
    assign w_clip_hi = (w_s > CTRL_MAX);
    assign w_clip_lo = (w_s < CTRL_MIN);
    assign w_ctrl    = w_clip_hi ? {1'b0, {(CONTROL_WIDTH-1){1'b1}}} :
                       w_clip_lo ? {1'b1, {(CONTROL_WIDTH-1){1'b0}}} :
                                   w_s[CONTROL_WIDTH-1:0];

`ifdef PID_MC_ANTIWINDUP_EN
    // Freeze the integrator only when it is pushing further into the clamp.
    assign w_hold = (w_clip_hi || w_clip_lo) && (r_e != '0) &&
                    (r_e[E_W-1] == w_s[SUM_W-1]);
`else
    assign w_hold = 1'b0;
`endif

    // The done state always drains to IDLE so the pulse is exactly one clk.
    always_comb begin
        w_next = r_state;
        if (r_state == S_DONE) begin
            w_next = S_IDLE;
        end else if (bus.clk_en) begin
            if (!bus.en) begin
                w_next = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  if (bus.start) w_next = S_ERR;
                    S_ERR:   w_next = S_MP;
                    S_MP:    w_next = S_MI;
                    S_MI:    w_next = S_MD;
                    S_MD:    w_next = S_OUT;
                    S_OUT:   w_next = w_last ? S_FIN : S_ERR;
                    S_FIN:   w_next = S_DONE;
                    default: w_next = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ch      <= '0;
            r_e       <= '0;
            r_acc_t   <= '0;
            r_sum     <= '0;
            r_sat     <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_kp[i]   <= '0;
                r_ki[i]   <= '0;
                r_kd[i]   <= '0;
                r_sp[i]   <= '0;
                r_fb[i]   <= '0;
                r_acc[i]  <= '0;
                r_prev[i] <= '0;
                r_err[i]  <= '0;
                r_ctrl[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (bus.clk_en && bus.start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (bus.clk_en) begin
                if (!bus.en) begin
                    r_ch  <= '0;
                    r_sat <= '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        r_acc[i]  <= '0;
                        r_prev[i] <= '0;
                        r_ctrl[i] <= '0;
                    end
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (bus.start) begin
                                r_ch <= '0;
                                for (int i = 0; i < NUM_CH; i++) begin
                                    r_kp[i] <= bus.k_p[i*PID_INT_WIDTH +: PID_INT_WIDTH];
                                    r_ki[i] <= bus.k_i[i*PID_INT_WIDTH +: PID_INT_WIDTH];
                                    r_kd[i] <= bus.k_d[i*PID_INT_WIDTH +: PID_INT_WIDTH];
                                    r_sp[i] <= bus.setpoint[i*PV_WIDTH +: PV_WIDTH];
                                    r_fb[i] <= bus.feedback[i*PV_WIDTH +: PV_WIDTH];
                                end
                            end
                        end
                        S_ERR: begin
                            r_e         <= w_e;
                            r_err[r_ch] <= w_e;
                            r_sum       <= '0;
                        end
                        S_MP, S_MD: begin
                            r_sum <= r_sum + SUM_W'(w_prod);
                        end
                        S_MI: begin
                            r_sum   <= r_sum + SUM_W'(w_prod);
                            r_acc_t <= w_acc_t;
                        end
                        S_OUT: begin
                            r_ctrl[r_ch] <= w_ctrl;
                            r_sat[r_ch]  <= w_clip_hi || w_clip_lo;
                            r_prev[r_ch] <= r_e;
                            r_acc[r_ch]  <= w_hold ? r_acc[r_ch] : r_acc_t;
                            if (!w_last) begin
                                r_ch <= r_ch + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_ctrl_bus = '0;
        w_err_bus  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ctrl_bus[i*CONTROL_WIDTH +: CONTROL_WIDTH] = r_ctrl[i];
            w_err_bus[i*E_W +: E_W]                      = r_err[i];
        end
    end

    assign bus.control_out = w_ctrl_bus;
    assign bus.error       = w_err_bus;
    assign bus.sat         = r_sat;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_pid_controller_mc.sv
// tb/tb_pid_controller_mc.sv - scoreboard bench for pid_controller_mc (OUT_SHIFT 0 and 4 in lockstep)
module tb_pid_controller_mc;
    logic clk;
    logic reset;

    pid_controller_mc_if #(.NUM_CH(2), .PID_INT_WIDTH(16), .PV_WIDTH(7), .CONTROL_WIDTH(18)) bus ();
    pid_controller_mc_if #(.NUM_CH(2), .PID_INT_WIDTH(16), .PV_WIDTH(7), .CONTROL_WIDTH(18)) bus4 ();

    pid_controller_mc #(.OUT_SHIFT(0)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    pid_controller_mc #(.OUT_SHIFT(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    assign bus4.clk_en   = bus.clk_en;
    assign bus4.en       = bus.en;
    assign bus4.start    = bus.start;
    assign bus4.k_p      = bus.k_p;
    assign bus4.k_i      = bus.k_i;
    assign bus4.k_d      = bus.k_d;
    assign bus4.setpoint = bus.setpoint;
    assign bus4.feedback = bus.feedback;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct {
        logic [35:0] ctrl;
        logic [35:0] ctrl4;
        logic [1:0]  sat;
        logic [1:0]  sat4;
        logic [15:0] err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;
    int   n_push   = 0;
    int   lat;

`ifdef PID_MC_ANTIWINDUP_EN
    localparam int AW_OUT  = 0;
    localparam int AW_OUT4 = 0;
`else
    localparam int AW_OUT  = 127;
    localparam int AW_OUT4 = 7;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Channel 1 is fixed at kp=2, sp=100, fb=50: e=50, out=100 (>>>4: 6).
    task automatic push(input int c0, input int c40, input bit s0, input bit s40, input int e0);
        exp_t x;
        x.ctrl  = {18'(100), 18'(c0)};
        x.ctrl4 = {18'(6), 18'(c40)};
        x.sat   = {1'b0, s0};
        x.sat4  = {1'b0, s40};
        x.err   = {8'(50), 8'(e0)};
        sb.push_back(x);
        n_push++;
    endtask

    task automatic set_ch0(input int kp, input int ki, input int kd, input int sp, input int fb);
        bus.k_p      = {16'd2, 16'(kp)};
        bus.k_i      = {16'd0, 16'(ki)};
        bus.k_d      = {16'd0, 16'(kd)};
        bus.setpoint = {7'd100, 7'(sp)};
        bus.feedback = {7'd50, 7'(fb)};
    endtask

    task automatic run_update(input int gap_at, input int gaps, input bit poke, output int l);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        l = -1;
        for (int n = 1; n <= 100 && l < 0; n++) begin
            @(negedge clk);
            bus.start  = poke && (n == 8);
            bus.clk_en = !(gaps > 0 && n >= gap_at && n < gap_at + gaps);
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) l = n;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.clk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t x;
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(n_done), 64'(n_push));
            end else begin
                x = sb.pop_front();
                chk("error", 64'(bus.error), 64'(x.err));
                chk("control_out", 64'(bus.control_out), 64'(x.ctrl));
                chk("sat", 64'(bus.sat), 64'(x.sat));
                chk("control_out_shift4", 64'(bus4.control_out), 64'(x.ctrl4));
                chk("sat_shift4", 64'(bus4.sat), 64'(x.sat4));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.clk_en = 1'b1;
        bus.en     = 1'b1;
        bus.start  = 1'b1;
        set_ch0(300, 100, 500, 30, 14);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_overrun", 64'(bus.overrun), 64'd0);
        chk("reset_control_out", 64'(bus.control_out), 64'd0);
        chk("reset_error", 64'(bus.error), 64'd0);
        chk("reset_sat", 64'(bus.sat), 64'd0);

        // Basic update, then repeat: acc=32, d=0.
        push(14400, 900, 1'b0, 1'b0, 16);
        run_update(0, 0, 1'b0, lat);
        chk("latency_basic", 64'(lat), 64'd11);
        push(8000, 500, 1'b0, 1'b0, 16);
        run_update(0, 0, 1'b0, lat);

        // Negative error, floor shift.
        set_ch0(300, 0, 0, 0, 14);
        push(-4200, -263, 1'b0, 1'b0, -14);
        run_update(0, 0, 1'b0, lat);

        // Abort at cycle 3 of an update.
        set_ch0(300, 100, 500, 30, 14);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(n_done), 64'd3);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_control_out", 64'(bus.control_out), 64'd0);
        chk("abort_sat", 64'(bus.sat), 64'd0);

        push(14400, 900, 1'b0, 1'b0, 16);
        run_update(0, 0, 1'b0, lat);

        // Clear integrators with en low in IDLE, then saturate.
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.en = 1'b1;
        #1;
        chk("clear_control_out", 64'(bus.control_out), 64'd0);
        set_ch0(65535, 1, 0, 127, 0);
        push(131071, 131071, 1'b1, 1'b1, 127);
        run_update(0, 0, 1'b0, lat);
        set_ch0(0, 1, 0, 50, 50);
        push(AW_OUT, AW_OUT4, 1'b0, 1'b0, 0);
        run_update(0, 0, 1'b0, lat);

        // Handshake: clk_en gaps and a start poke while busy.
        chk("overrun_before", 64'(bus.overrun), 64'd0);
        set_ch0(300, 0, 0, 30, 14);
        push(4800, 300, 1'b0, 1'b0, 16);
        run_update(3, 4, 1'b1, lat);
        chk("latency_gaps", 64'(lat), 64'd15);
        repeat (20) @(posedge clk);
        #1;
        chk("overrun_after", 64'(bus.overrun), 64'd1);
        chk("busy_idle", 64'(bus.busy), 64'd0);
        chk("done_count", 64'(n_done), 64'(n_push));
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pid_controller_mc.md
# pid_controller_mc

Time-multiplexed, multi-channel PID controller for the wall follower: one shared multiplier serially computes an independent PID update for each of NUM_CH distance channels, e.g. left and right wall sensors. It sits between the distance-sensor front end, which supplies setpoint and feedback, and the PWM generators, which consume `control_out`. Beyond the single-channel controller, it adds:

- per-channel integrator saturation;
- a start/busy/done handshake;
- an output arithmetic shift for fractional gains;
- optional anti-windup.

## Interface
- NUM_CH, 2, number of independent channels (≥1)
- PID_INT_WIDTH, 16, unsigned gain width
- PV_WIDTH, 7, unsigned setpoint/feedback width; ERROR_WIDTH = PV_WIDTH+1
- CONTROL_WIDTH, 18, signed output width
- ACC_WIDTH, 16, signed integrator width (≥ ERROR_WIDTH)
- OUT_SHIFT, 0, arithmetic right shift applied to the PID sum before saturation

Ports:
- clk  in  1  system clock, 125 MHz
- reset  in  1  synchronous, active-high; sampled on rising clk regardless of clk_en
- clk_en  in  1  clock enable; FSM, latches and integrators advance only when high
- en  in  1  controller enable; low forces the idle/cleared state
- start  in  1  request one update of all channels; sampled in IDLE with clk_en=1
- k_p, k_i, k_d  in  NUM_CH*PID_INT_WIDTH each  packed per-channel gains, ch0 in LSBs
- setpoint, feedback  in  NUM_CH*PV_WIDTH each  packed unsigned process values
- busy  out  1  high whenever FSM ≠ IDLE
- done  out  1  one-clk pulse when all control_out are updated
- overrun  out  1  sticky: start seen while busy; cleared only by reset
- sat  out  NUM_CH  per-channel flag: last output was clamped
- error  out  NUM_CH*ERROR_WIDTH  latched signed error per channel
- control_out  out  NUM_CH*CONTROL_WIDTH  signed control per channel

## Operation
- **Reset** clears all of the following to 0, and the FSM enters IDLE:
  - outputs: control_out, error, sat, busy, done, overrun;
  - internal state: integrators, prev_error.
- **Start in IDLE** (start=1, en=1): latch all gains, setpoints and feedbacks; ch index ← 0.
- **Per-channel states**: ERR → MP → MI → MD → OUT. Each state takes one enabled cycle.
  - ERR: e = zext(setpoint) − zext(feedback), ERROR_WIDTH signed.
  - MP: accumulate k_p·e.
  - MI: acc_t = sat_ACC(acc + e), clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]; accumulate k_i·acc_t.
  - MD: d = e − prev_error (ERROR_WIDTH+1 bits); accumulate k_d·d.
  - OUT: s = sum >>> OUT_SHIFT (floor). control_out[ch] = s clamped to CONTROL_WIDTH signed range. sat[ch] = clamped. Commit acc and prev_error ← e.
  - After OUT, go to ERR of the next channel; after the last channel, go to DONE.
- **Gains** are zero-extended to signed before multiplying. The running sum is full precision (no intermediate truncation).
- **DONE**: done=1 for one clk; return to IDLE.
- **start while busy**: ignored (no queue); sets overrun.
- **en=0 at any enabled cycle**: abort to IDLE; clear integrators, prev_error, control_out and sat; no done pulse.
- **Reset mid-operation**: same as a power-on reset.

## Timing
- With clk_en held high, the start-sampling edge to the done-high edge is 5·NUM_CH+1 edges (11 at default).
- Each clk_en=0 cycle extends latency by one cycle; state and outputs are held. The done pulse lasts exactly one clk even if clk_en is low on the following cycle.
- control_out[ch] and sat[ch] update on that channel's OUT edge. All channels are valid when done=1.
- start may be asserted in the cycle done is high; it is ignored because the FSM is still busy, and it sets overrun. It is accepted from the next IDLE cycle.
- busy rises on the edge after start is sampled and falls on the edge after done.

## Configuration
- PID_MC_ANTIWINDUP_EN defined: conditional integration. At OUT, if the channel saturated, e≠0, and sign(e) equals the sign of the unclamped s, the integrator keeps its pre-update value instead of acc_t. The output still uses acc_t.
- Not defined: acc_t is always committed; the integrator is bounded only by ACC_WIDTH clamping.

## Test plan
- **Reset**: reset high for 3 cycles → all outputs 0, busy=0, FSM idle; start during reset is ignored.
- **Basic update**: ch0 kp=300, ki=100, kd=500, sp=30, fb=14, start → error=16, control_out[0]=14400, done 11 cycles later. Repeat with the same inputs → 8000 (acc=32, d=0).
- **Negative error and shift**: sp=0, fb=14, kp=300, ki=kd=0 → −4200. With OUT_SHIFT=4 → −263 (floor). sat=0.
- **Saturation and anti-windup**:
  - Step 1: kp=65535, ki=1, sp=127, fb=0 → control_out=131071, sat=1.
  - Step 2: kp=kd=0, sp=fb → output 0 with PID_MC_ANTIWINDUP_EN defined, 127 without.
- **Handshake**: start pulses during busy → overrun=1, exactly one done. Insert 4 clk_en-low cycles → done at edge 15.
- **Abort**: en=0 at cycle 3 of an update → no done, busy=0, control_out=0. The next update with sp=30, fb=14 reproduces 14400.
